send_all: RTL and testbench
===========================

Name: send_all

Overview:
- Transmitting end of the inter-board Request/Ack link. It serialises one game message onto the 6-bit interboard_data bus as six words: msg_type, block_x, block_y, card, sel_len, move_dir.
- Sits between the local game controller, which issues one-pulse send commands, and the board pins that feed the other board's receiver.
- One word-level handshake engine, single_send, is instantiated beneath a six-word sequencer.

Parameters:
- GAP_CYCLES, 2, idle cycles with Request low after Ack falls before the next word's Request rises (range 1..15).
- SYNC_STAGES, 2, flip-flop depth of the Ack input synchroniser (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  local reset; synchronous, active-high
- interboard_rst  input  1  link abort; synchronous, active-high, same effect as rst
- Ack  input  1  from other board; asynchronous to clk
- ctrl_en  input  1  one-pulse send command from controller
- ctrl_msg_type  input  4  message type
- ctrl_block_x  input  5  block column
- ctrl_block_y  input  3  block row
- ctrl_card  input  6  card code
- ctrl_sel_len  input  3  selection length
- ctrl_move_dir  input  1  move direction
- Request  output  1  to other board; registered
- interboard_data  output  6  to other board; registered
- busy  output  1  high from the cycle after an accepted ctrl_en until done
- done  output  1  one-pulse; the whole message has been acknowledged

Behaviour:
- Reset: rst or interboard_rst, sampled at a clk edge.
  - Request=0, interboard_data=0, busy=0, done=0.
  - Synchroniser flops cleared, field registers cleared, both FSMs idle, counters 0.
  - Reset mid-message drops Request on the next edge. The message is discarded; there is no resume.
- Ack synchronisation: Ack passes through SYNC_STAGES flip-flops to form ack_s. Only ack_s is used internally.
- Command acceptance:
  - ctrl_en with busy=0 latches all six fields in that cycle, and busy=1 from the next cycle.
  - ctrl_en while busy=1 is ignored and the fields are not re-latched.
  - ctrl_en in the same cycle as done is ignored.
- Field mapping: each field is zero-extended to 6 bits (msg_type→{2'b0,msg_type}, move_dir→{5'b0,dir}, etc.).
- Sequencer FSM:
  - States: IDLE, W1..W6 (one per word), FINISH.
  - IDLE→W1 on accepted ctrl_en.
  - Wn→Wn+1 on word_done from single_send; W6→FINISH on word_done.
  - FINISH lasts exactly one cycle with done=1, then →IDLE.
  - The sequencer asserts word_start in the first cycle of each Wn. single_send presents the word for state Wn.
- single_send FSM:
  - IDLE: Request=0. On word_start, register the data and go to REQ.
  - REQ: Request=1, data stable. On ack_s=1 go to HOLD.
  - HOLD: Request=0, data stable. On ack_s=0 go to GAP.
  - GAP: Request=0, data stable. Counts GAP_CYCLES; on the last count pulse word_done and go to IDLE.
- Data stability: interboard_data is held from the first REQ cycle until the word ends. The receiver samples continuously through its Ack window, so any change in that window corrupts the word.
- Latency:
  - Request rises the cycle after word_start.
  - Request falls SYNC_STAGES+1 cycles after Ack rises at the pin.
  - Minimum per-word time ≈ remote Ack width + 2·SYNC_STAGES + GAP_CYCLES + 2.
- Request dropping rule: Request must drop before the receiver's Ack window ends (11 receiver cycles). Otherwise the receiver re-acknowledges the same word. This constrains SYNC_STAGES ≤ 4 at equal clock rates.
- No timeout: if Ack never arrives, the block stays in REQ with busy=1 until rst or interboard_rst.
- Glitch tolerance: an ack_s pulse while single_send is in IDLE or GAP is ignored.
- Outputs are never driven to the pattern Request=1 with data=6'h3F other than as a real word.

Decomposition:
- Shared package (interboard_pkg):
  - field widths (MSG_W=4, BX_W=5, BY_W=3, CARD_W=6, LEN_W=3).
  - DATA_W=6, WORD_COUNT=6.
  - sequencer state encodings matching the receiver's WAIT_1..FINISH ordering.
- Sub-module single_send: word handshake, Ack synchroniser, gap counter.
- send_all: command latch, word mux, sequencer.

Test Plan:
- Basic message: rst, then ctrl_en with msg_type=4'hA, block_x=5'd17, block_y=3'd5, card=6'd42, sel_len=3'd3, move_dir=1. The bench emulates the receiver: Ack high 11 cycles, 3 cycles after Request. Required: data words 10, 17, 5, 42, 3, 1 in order; exactly six Request pulses; one done pulse; busy low after done.
- Data stability: same stimulus. Assert interboard_data is unchanged in every cycle where Request=1 or the bench Ack=1 → zero violations.
- Busy rejection: second ctrl_en with card=6'd7 during word 3 → transmitted card stays 42; no second message follows.
- Late Ack: receiver delays Ack by 500 cycles on word 2 → Request stays 1 and data stays 17 throughout; completion then proceeds normally.
- Abort: interboard_rst pulsed while in REQ of word 4 → next cycle Request=0, data=0, busy=0, no done. A new ctrl_en then sends the full six words from word 1.
- Zero-extension and gap: move_dir=0, msg_type=4'hF, GAP_CYCLES=3 → word 1 = 6'h0F, word 6 = 6'h00. At least 3 cycles with Request low between ack_s fall and the next Request rise.

Source files
------------

// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board Request/Ack link.
// Holds the message field widths, the bus width, the sequencer state
// encodings (ordered to match the receiver's WAIT_1..FINISH states), the
// word-handshake state encodings, the latched message record and the
// helper that maps a sequencer state to the zero-extended bus word.
package interboard_pkg;

    localparam int DATA_W     = 6;
    localparam int WORD_COUNT = 6;
    localparam int MSG_W      = 4;
    localparam int BX_W       = 5;
    localparam int BY_W       = 3;
    localparam int CARD_W     = 6;
    localparam int LEN_W      = 3;
    localparam int DIR_W      = 1;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_W1     = 3'd1,
        SEQ_W2     = 3'd2,
        SEQ_W3     = 3'd3,
        SEQ_W4     = 3'd4,
        SEQ_W5     = 3'd5,
        SEQ_W6     = 3'd6,
        SEQ_FINISH = 3'd7
    } seq_state_t;

    typedef enum logic [1:0] {
        SS_IDLE = 2'd0,
        SS_REQ  = 2'd1,
        SS_HOLD = 2'd2,
        SS_GAP  = 2'd3
    } ss_state_t;

    typedef struct packed {
        logic [MSG_W-1:0]  msg_type;
        logic [BX_W-1:0]   block_x;
        logic [BY_W-1:0]   block_y;
        logic [CARD_W-1:0] card;
        logic [LEN_W-1:0]  sel_len;
        logic [DIR_W-1:0]  move_dir;
    } msg_t;

    // Word presented on the bus while the sequencer sits in state s.
    function automatic logic [DATA_W-1:0] msg_word(input msg_t m, input seq_state_t s);
        logic [DATA_W-1:0] w;
        w = '0;
        case (s)
            SEQ_W1:  w = DATA_W'(m.msg_type);
            SEQ_W2:  w = DATA_W'(m.block_x);
            SEQ_W3:  w = DATA_W'(m.block_y);
            SEQ_W4:  w = DATA_W'(m.card);
            SEQ_W5:  w = DATA_W'(m.sel_len);
            SEQ_W6:  w = DATA_W'(m.move_dir);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/send_all_single_send.sv
// single_send: one-word Request/Ack handshake engine.
// Synchronises the remote Ack, raises Request with the registered word,
// drops Request once Ack is seen, waits for Ack to fall, then idles for
// GAP_CYCLES before pulsing word_done.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ack             remote Ack pin (asynchronous to clk)
//   word_start      one-cycle pulse: capture word and start the handshake
//   word            word to send
//   request         registered Request to the remote board
//   data            registered bus word, stable from REQ to end of word
//   word_done       one-cycle pulse when the word is fully complete
import interboard_pkg::*;

module single_send #(
    parameter int GAP_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ack,
    input  logic              word_start,
    input  logic [DATA_W-1:0] word,
    output logic              request,
    output logic [DATA_W-1:0] data,
    output logic              word_done
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s;
    ss_state_t              state;
    logic [3:0]             gap_cnt;

    assign ack_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            state     <= SS_IDLE;
            request   <= 1'b0;
            data      <= '0;
            gap_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], ack};
            word_done <= 1'b0;
            case (state)
                // ack_s is ignored here, so stray Ack pulses cannot start anything
                SS_IDLE: begin
                    if (word_start) begin
                        data    <= word;
                        request <= 1'b1;
                        state   <= SS_REQ;
                    end
                end
                // No timeout: waits for Ack indefinitely
                SS_REQ: begin
                    if (ack_s) begin
                        request <= 1'b0;
                        state   <= SS_HOLD;
                    end
                end
                SS_HOLD: begin
                    if (!ack_s) begin
                        gap_cnt <= '0;
                        state   <= SS_GAP;
                    end
                end
                // data is left untouched until the next word_start
                SS_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        word_done <= 1'b1;
                        state     <= SS_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= SS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/send_all.sv
// send_all: transmitting end of the inter-board Request/Ack link.
// Latches a six-field game message on a ctrl_en pulse and sends it as six
// zero-extended 6-bit words (msg_type, block_x, block_y, card, sel_len,
// move_dir) through one single_send handshake engine.
// Ports:
//   clk, rst, interboard_rst   clock and two synchronous active-high resets
//   Ack                        remote acknowledge (asynchronous)
//   ctrl_en, ctrl_*            one-pulse send command and message fields
//   Request, interboard_data   registered link outputs
//   busy                       message in progress
//   done                       one-cycle pulse, whole message acknowledged
import interboard_pkg::*;

module send_all #(
    parameter int GAP_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interboard_rst,
    input  logic              Ack,
    input  logic              ctrl_en,
    input  logic [MSG_W-1:0]  ctrl_msg_type,
    input  logic [BX_W-1:0]   ctrl_block_x,
    input  logic [BY_W-1:0]   ctrl_block_y,
    input  logic [CARD_W-1:0] ctrl_card,
    input  logic [LEN_W-1:0]  ctrl_sel_len,
    input  logic [DIR_W-1:0]  ctrl_move_dir,
    output logic              Request,
    output logic [DATA_W-1:0] interboard_data,
    output logic              busy,
    output logic              done
);

    logic              rst_all;
    seq_state_t        state;
    msg_t              msg;
    logic              word_start;
    logic              word_done;
    logic [DATA_W-1:0] word;

    // A link abort behaves exactly like a local reset: the message is dropped.
    assign rst_all = rst | interboard_rst;
    assign word    = msg_word(msg, state);

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state      <= SEQ_IDLE;
            msg        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_start <= 1'b0;
        end else begin
            word_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (ctrl_en && !busy) begin
                        msg        <= '{msg_type: ctrl_msg_type, block_x: ctrl_block_x,
                                        block_y: ctrl_block_y, card: ctrl_card,
                                        sel_len: ctrl_sel_len, move_dir: ctrl_move_dir};
                        busy       <= 1'b1;
                        word_start <= 1'b1;
                        state      <= SEQ_W1;
                    end
                end
                SEQ_W1: if (word_done) begin state <= SEQ_W2; word_start <= 1'b1; end
                SEQ_W2: if (word_done) begin state <= SEQ_W3; word_start <= 1'b1; end
                SEQ_W3: if (word_done) begin state <= SEQ_W4; word_start <= 1'b1; end
                SEQ_W4: if (word_done) begin state <= SEQ_W5; word_start <= 1'b1; end
                SEQ_W5: if (word_done) begin state <= SEQ_W6; word_start <= 1'b1; end
                SEQ_W6: if (word_done) begin state <= SEQ_FINISH; done <= 1'b1; end
                // busy stays high through the done cycle, so a ctrl_en there is ignored
                SEQ_FINISH: begin
                    busy  <= 1'b0;
                    state <= SEQ_IDLE;
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    single_send #(
        .GAP_CYCLES  (GAP_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_single_send (
        .clk        (clk),
        .rst        (rst_all),
        .ack        (Ack),
        .word_start (word_start),
        .word       (word),
        .request    (Request),
        .data       (interboard_data),
        .word_done  (word_done)
    );

endmodule

// File: tb/tb_send_all.sv
// Bench for send_all: emulates the remote receiver and checks the word
// stream against a field-level model of the message.
module tb_send_all;

    localparam int GAP  = 3;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst, interboard_rst, Ack, ctrl_en;
    logic [3:0] ctrl_msg_type;
    logic [4:0] ctrl_block_x;
    logic [2:0] ctrl_block_y;
    logic [5:0] ctrl_card;
    logic [2:0] ctrl_sel_len;
    logic [0:0] ctrl_move_dir;
    logic       Request, busy, done;
    logic [5:0] interboard_data;

    always #5 clk = ~clk;

    send_all #(.GAP_CYCLES(GAP), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .Ack(Ack),
        .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type), .ctrl_block_x(ctrl_block_x),
        .ctrl_block_y(ctrl_block_y), .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len),
        .ctrl_move_dir(ctrl_move_dir), .Request(Request), .interboard_data(interboard_data),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control written by the main flow, read by the receiver.
    int msg_id     = 0;
    int late_word  = 0;
    int abort_word = 0;
    int ack_dly    = 3;
    int ack_wid    = 11;

    // Receiver emulation: owns Ack and the captured word list.
    logic [5:0] rx_words[$];
    initial begin
        int seen_id = 0;
        int idx = 0;
        Ack = 1'b0;
        forever begin
            @(negedge clk);
            if (msg_id != seen_id) begin
                seen_id = msg_id;
                idx = 0;
                rx_words.delete();
            end
            if (Request === 1'b1) begin
                idx++;
                if (idx == abort_word) begin
                    for (int k = 0; k < 5000 && Request === 1'b1; k++) @(negedge clk);
                end else begin
                    repeat (ack_dly + ((idx == late_word) ? 500 : 0)) @(posedge clk);
                    #1 Ack = 1'b1;
                    @(negedge clk);
                    rx_words.push_back(interboard_data);
                    repeat (ack_wid) @(posedge clk);
                    #1 Ack = 1'b0;
                    for (int k = 0; k < 5000 && Request === 1'b1; k++) @(negedge clk);
                end
            end
        end
    end

    // Link monitor: counts events and timing/stability violations.
    int req_rises = 0, done_cnt = 0, stab_viol = 0, lat_bad = 0;
    int gap_min = 100000;
    initial begin
        int cyc = 0, t_ack = 0, t_af = 0;
        bit armed = 0;
        logic req_p = 0, ack_p = 0, done_p = 0;
        logic [5:0] data_p = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if ((Request || Ack) && (req_p || ack_p) && interboard_data !== data_p) stab_viol++;
            if (Request && !req_p) begin
                req_rises++;
                if (armed && (cyc - t_af) < gap_min) gap_min = cyc - t_af;
                armed = 0;
            end
            if (Ack && !ack_p) t_ack = cyc;
            if (!Ack && ack_p) begin t_af = cyc; armed = 1; end
            if (!Request && req_p && Ack && (cyc - t_ack) != SYNC + 1) lat_bad++;
            if (done && !done_p) done_cnt++;
            req_p = Request; ack_p = Ack; done_p = done; data_p = interboard_data;
        end
    end

    // Reference model: message fields, zero-extended words.
    int fld[6];
    int r0, d0, v0, l0;

    task automatic start_msg();
        r0 = req_rises; d0 = done_cnt; v0 = stab_viol; l0 = lat_bad;
        msg_id++;
        @(posedge clk); #1;
        ctrl_msg_type = 4'(fld[0]); ctrl_block_x = 5'(fld[1]); ctrl_block_y = 3'(fld[2]);
        ctrl_card = 6'(fld[3]); ctrl_sel_len = 3'(fld[4]); ctrl_move_dir = 1'(fld[5]);
        ctrl_en = 1'b1;
        @(posedge clk); #1 ctrl_en = 1'b0;
        @(negedge clk);
        check_val("busy_after_accept", busy, 1);
    endtask

    task automatic finish_msg(input string name);
        bit seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check_val({name, "_done_seen"}, seen, 1);
        @(negedge clk);
        check_val({name, "_busy_low_after_done"}, busy, 0);
        check_val({name, "_done_one_pulse"}, done, 0);
        check_val({name, "_words_rx"}, rx_words.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < rx_words.size())
                check_val($sformatf("%s_word%0d", name, i + 1), rx_words[i], fld[i]);
        check_val({name, "_req_pulses"}, req_rises - r0, 6);
        check_val({name, "_done_pulses"}, done_cnt - d0, 1);
        check_val({name, "_stability"}, stab_viol - v0, 0);
        check_val({name, "_req_fall_latency"}, lat_bad - l0, 0);
    endtask

    task automatic wait_reqs(input int n);
        for (int k = 0; k < 3000 && (req_rises - r0) < n; k++) @(negedge clk);
        check_val($sformatf("reached_word%0d", n), req_rises - r0, n);
    endtask

    initial begin
        rst = 1'b1; interboard_rst = 1'b0; ctrl_en = 1'b0;
        ctrl_msg_type = '0; ctrl_block_x = '0; ctrl_block_y = '0;
        ctrl_card = '0; ctrl_sel_len = '0; ctrl_move_dir = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_request", Request, 0);
        check_val("rst_data", interboard_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic message
        fld = '{10, 17, 5, 42, 3, 1};
        start_msg();
        finish_msg("basic");

        // Busy rejection: second command during word 3
        start_msg();
        wait_reqs(3);
        @(posedge clk); #1 ctrl_card = 6'd7; ctrl_en = 1'b1;
        @(posedge clk); #1 ctrl_en = 1'b0;
        finish_msg("busyrej");
        repeat (200) @(negedge clk);
        check_val("busyrej_no_second_msg", req_rises - r0, 6);
        check_val("busyrej_idle", busy, 0);

        // Late Ack on word 2
        late_word = 2;
        start_msg();
        finish_msg("late");
        late_word = 0;

        // Abort in REQ of word 4
        abort_word = 4;
        start_msg();
        wait_reqs(4);
        repeat (5) @(negedge clk);
        check_val("abort_in_req", Request, 1);
        @(posedge clk); #1 interboard_rst = 1'b1;
        @(posedge clk); #1 interboard_rst = 1'b0;
        @(negedge clk);
        check_val("abort_request", Request, 0);
        check_val("abort_data", interboard_data, 0);
        check_val("abort_busy", busy, 0);
        repeat (50) @(negedge clk);
        check_val("abort_no_done", done_cnt - d0, 0);
        abort_word = 0;
        start_msg();
        finish_msg("after_abort");

        // Zero-extension corners
        fld = '{15, 31, 7, 63, 7, 0};
        start_msg();
        finish_msg("zext");

        // Randomized messages and receiver timing
        for (int m = 0; m < 4; m++) begin
            fld[0] = int'($urandom_range(15)); fld[1] = int'($urandom_range(31));
            fld[2] = int'($urandom_range(7));  fld[3] = int'($urandom_range(63));
            fld[4] = int'($urandom_range(7));  fld[5] = int'($urandom_range(1));
            ack_dly = int'($urandom_range(1, 6));
            ack_wid = int'($urandom_range(6, 11));
            start_msg();
            finish_msg($sformatf("rand%0d", m));
        end

        // Request stays low for the synchroniser delay plus the full gap
        check_val("gap_min_ok", (gap_min >= GAP + SYNC) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
